shift_right_collect: RTL

Serial-in/parallel-out deserializer that is the receive end of the team's parallel-load left-shift serializer. It samples one serial bit per enabled clock, assembles WIDTH bits into a word, and presents the word on a held output register with a valid/ready handshake. It also provides a word-alignment input and a sticky overrun flag. It sits between a serial link and a parallel consumer, such as a register file or FIFO.

---
 rtl/shift_right_collect.sv | 96 +++++++++
 1 files changed

// File: rtl/shift_right_collect.sv
// shift_right_collect
//   Serial-in/parallel-out deserializer. Collects one SIn bit per clock with
//   SEn=1, assembles WIDTH bits into a word, and presents it on a held output
//   register with a Valid/Ready handshake. Sync restarts word assembly, and
//   Overrun sticks high once a completed word has been dropped.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: first received bit lands in D[WIDTH-1]; 0: lands in D[0]
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   SIn      serial data bit, sampled when SEn=1
//   SEn      bit-valid strobe
//   Sync     word alignment: clears the partial word before this cycle's shift
//   Ready    consumer accepts D when Valid=1 and Ready=1
//   D        last completed word, held until replaced
//   Valid    D holds an unconsumed word
//   Overrun  sticky: a completed word was dropped
//   BitCnt   bits collected in the current word
module shift_right_collect #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     SIn,
  input  logic                     SEn,
  input  logic                     Sync,
  input  logic                     Ready,
  output logic [WIDTH-1:0]         D,
  output logic                     Valid,
  output logic                     Overrun,
  output logic [$clog2(WIDTH)-1:0] BitCnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_base;
  logic [WIDTH-1:0] sreg_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             complete;

  // Sync clears the partial word ahead of the shift, so a bit arriving in the
  // same cycle becomes bit 0 of the new word and can never complete a word.
  always_comb begin
    sreg_base = Sync ? '0 : sreg;
    sreg_next = sreg_base;
    cnt_next  = Sync ? '0 : cnt;
    complete  = 1'b0;
    if (SEn) begin
      if (MSB_FIRST) begin
        sreg_next = {sreg_base[WIDTH-2:0], SIn};
      end else begin
        sreg_next = {SIn, sreg_base[WIDTH-1:1]};
      end
      if (!Sync && (cnt == LAST)) begin
        complete = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_next + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      cnt     <= '0;
      D       <= '0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      sreg <= sreg_next;
      cnt  <= cnt_next;
      if (complete) begin
        // A word arriving while the consumer takes the old one replaces it
        // without a Valid gap; otherwise a pending word blocks and it drops.
        if (!Valid || Ready) begin
          D     <= sreg_next;
          Valid <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (Valid && Ready) begin
        Valid <= 1'b0;
      end
    end
  end

  assign BitCnt = cnt;

endmodule
